mem_wb_stage: RTL and testbench



---
 rtl/mem_wb_stage.sv | 143 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM->WB boundary: valid/ready handshake through a 2-entry skid buffer (main M, skid S),
// with load-lane extraction and extension done before capture so WB sees register-ready data.
module mem_wb_stage #(
    parameter int                DATA_W   = 32,
    parameter int                REG_AW   = 5,
    parameter logic [DATA_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [1:0]        MemtoReg_in,
    input  logic              RegWr_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] rd_data_in,
    input  logic [DATA_W-1:0] alu_out_in,
    input  logic [DATA_W-1:0] ra_in,
    input  logic [REG_AW-1:0] wr_addr_in,
    input  logic [1:0]        addr_in,
    input  logic [1:0]        ld_size_in,
    input  logic              ld_signed_in,
    output logic [1:0]        MemtoReg_out,
    output logic              RegWr_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] alu_out_out,
    output logic [DATA_W-1:0] ra_out,
    output logic [DATA_W-1:0] rd_data_out,
    output logic [REG_AW-1:0] wr_addr_out,
    output logic [1:0]        addr_out,
    output logic              misalign_out
);

    typedef struct packed {
        logic [1:0]        memtoReg;
        logic              regWr;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rdData;
        logic [DATA_W-1:0] aluOut;
        logic [DATA_W-1:0] ra;
        logic [REG_AW-1:0] wrAddr;
        logic [1:0]        addr;
        logic              misalign;
    } entry_t;

    function automatic logic [DATA_W-1:0] extractLoad(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        addr,
        input logic [1:0]        size,
        input logic              sgn
    );
        logic        [7:0]        b;
        logic        [15:0]       h;
        logic signed [DATA_W-1:0] ext;
        case (addr)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = addr[1] ? word[31:16] : word[15:0];
        if (size[1])
            ext = word;
        else if (size[0])
            ext = {{(DATA_W-16){sgn & h[15]}}, h};
        else
            ext = {{(DATA_W-8){sgn & b[7]}}, b};
        return ext;
    endfunction

    entry_t inEnt, mEnt, sEnt;
    logic   mVld, sVld;
    logic   accept, consume, mFree;
    logic   loadMfromS, loadMfromIn, loadS;

    always_comb begin
        inEnt          = '0;
        inEnt.memtoReg = MemtoReg_in;
        inEnt.regWr    = RegWr_in;
        inEnt.pc       = pc_in;
        inEnt.rdData   = extractLoad(rd_data_in, addr_in, ld_size_in, ld_signed_in);
        inEnt.aluOut   = alu_out_in;
        inEnt.ra       = ra_in;
        inEnt.wrAddr   = wr_addr_in;
        inEnt.addr     = addr_in;
        inEnt.misalign = ((ld_size_in == 2'b01) & addr_in[0]) |
                         (ld_size_in[1] & (addr_in != 2'b00));
    end

    // S can only be full while M is also full, so accept never coincides with S->M.
    assign accept      = in_valid & ~sVld;
    assign consume     = mVld & out_ready;
    assign mFree       = ~mVld | consume;
    assign loadMfromS  = ~flush & mFree & sVld;
    assign loadMfromIn = ~flush & mFree & ~sVld & accept;
    assign loadS       = ~flush & ~mFree & accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mVld <= 1'b0;
            sVld <= 1'b0;
        end else if (flush) begin
            mVld <= 1'b0;
            sVld <= 1'b0;
        end else begin
            if (mFree)
                mVld <= sVld | accept;
            sVld <= mFree ? 1'b0 : (sVld | accept);
        end
    end

    // M capture: drives the WB-facing outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mEnt    <= '0;
            mEnt.pc <= RESET_PC;
        end else if (loadMfromS) begin
            mEnt <= sEnt;
        end else if (loadMfromIn) begin
            mEnt <= inEnt;
        end
    end

    always_ff @(posedge clk) begin
        if (loadS)
            sEnt <= inEnt;
    end

    assign in_ready     = ~sVld;
    assign out_valid    = mVld;
    assign MemtoReg_out = mEnt.memtoReg;
    assign RegWr_out    = mEnt.regWr & mVld & (mEnt.wrAddr != '0);
    assign pc_out       = mEnt.pc;
    assign alu_out_out  = mEnt.aluOut;
    assign ra_out       = mEnt.ra;
    assign rd_data_out  = mEnt.rdData;
    assign wr_addr_out  = mEnt.wrAddr;
    assign addr_out     = mEnt.addr;
    assign misalign_out = mEnt.misalign;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: load-extraction vector table, handshake/flush/reset sequences,
// and randomized traffic against a queue-based FIFO model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  MemtoReg_in, MemtoReg_out, addr_in, addr_out, ld_size_in;
    logic        RegWr_in, RegWr_out, ld_signed_in, misalign_out;
    logic [31:0] pc_in, rd_data_in, alu_out_in, ra_in;
    logic [31:0] pc_out, alu_out_out, ra_out, rd_data_out;
    logic [4:0]  wr_addr_in, wr_addr_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.DATA_W(32), .REG_AW(5), .RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .MemtoReg_in(MemtoReg_in), .RegWr_in(RegWr_in), .pc_in(pc_in),
        .rd_data_in(rd_data_in), .alu_out_in(alu_out_in), .ra_in(ra_in),
        .wr_addr_in(wr_addr_in), .addr_in(addr_in), .ld_size_in(ld_size_in),
        .ld_signed_in(ld_signed_in),
        .MemtoReg_out(MemtoReg_out), .RegWr_out(RegWr_out), .pc_out(pc_out),
        .alu_out_out(alu_out_out), .ra_out(ra_out), .rd_data_out(rd_data_out),
        .wr_addr_out(wr_addr_out), .addr_out(addr_out), .misalign_out(misalign_out)
    );

    typedef struct {
        logic [1:0]  memtoReg;
        logic        regWr;
        logic [31:0] pc, rd, alu, ra;
        logic [4:0]  wr;
        logic [1:0]  addr, size;
        logic        sgn;
    } ent_t;

    typedef struct {
        logic [31:0] rd;
        logic [1:0]  addr, size;
        logic        sgn;
        logic [4:0]  wr;
        logic        rw;
        logic [31:0] expData;
        logic        expMis, expRw;
    } vec_t;

    ent_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] refLoad(logic [31:0] rd, logic [1:0] addr,
                                            logic [1:0] size, logic sgn);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (rd >> (8 * addr)) & 32'hFF;
            if (sgn && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (rd >> (16 * addr[1])) & 32'hFFFF;
            if (sgn && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic refMis(logic [1:0] addr, logic [1:0] size);
        if (size == 2'd1) return addr[0];
        if (size >= 2'd2) return addr != 2'd0;
        return 1'b0;
    endfunction

    task automatic idle();
        in_valid = 0; flush = 0;
        MemtoReg_in = 0; RegWr_in = 1; pc_in = 0; rd_data_in = 0; alu_out_in = 0;
        ra_in = 0; wr_addr_in = 5'd3; addr_in = 0; ld_size_in = 2'd2; ld_signed_in = 0;
    endtask

    task automatic push(input logic [31:0] pc);
        in_valid = 1; pc_in = pc;
    endtask

    task automatic drive(input ent_t e);
        MemtoReg_in = e.memtoReg; RegWr_in = e.regWr; pc_in = e.pc; rd_data_in = e.rd;
        alu_out_in = e.alu; ra_in = e.ra; wr_addr_in = e.wr; addr_in = e.addr;
        ld_size_in = e.size; ld_signed_in = e.sgn;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        idle(); reset = 1;
        #2 reset = 0;
        q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[8];
        ent_t e;
        logic acc, cons;

        vt[0] = '{32'h80F1_7F82, 2'd1, 2'd0, 1'b1, 5'd5, 1'b1, 32'h0000_007F, 1'b0, 1'b1};
        vt[1] = '{32'h80F1_7F82, 2'd3, 2'd0, 1'b1, 5'd5, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b1};
        vt[2] = '{32'h80F1_7F82, 2'd2, 2'd1, 1'b1, 5'd5, 1'b1, 32'hFFFF_80F1, 1'b0, 1'b1};
        vt[3] = '{32'h80F1_7F82, 2'd2, 2'd1, 1'b0, 5'd5, 1'b1, 32'h0000_80F1, 1'b0, 1'b1};
        vt[4] = '{32'h80F1_7F82, 2'd2, 2'd2, 1'b0, 5'd5, 1'b1, 32'h80F1_7F82, 1'b1, 1'b1};
        vt[5] = '{32'h80F1_7F82, 2'd1, 2'd1, 1'b1, 5'd5, 1'b1, 32'h0000_7F82, 1'b1, 1'b1};
        vt[6] = '{32'h80F1_7F82, 2'd0, 2'd0, 1'b0, 5'd0, 1'b1, 32'h0000_0082, 1'b0, 1'b0};
        vt[7] = '{32'h80F1_7F82, 2'd0, 2'd0, 1'b0, 5'd5, 1'b1, 32'h0000_0082, 1'b0, 1'b1};

        idle(); out_ready = 1; reset = 1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_pc_out", pc_out, 32'h8000_0000);
        chk("rst_regwr", 32'(RegWr_out), 32'd0);
        chk("rst_rd_data", rd_data_out, 32'd0);
        @(negedge clk); reset = 0;

        // streaming, one per cycle, no bubbles
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("stream_valid", 32'(out_valid), 32'd1);
                chk("stream_pc", pc_out, 32'h100 + 32'(4 * (i - 1)));
            end
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            if (i < 4) push(32'h100 + 32'(4 * i)); else in_valid = 0;
        end
        @(negedge clk);
        chk("stream_drained", 32'(out_valid), 32'd0);

        // backpressure
        out_ready = 0; push(32'h200);
        @(negedge clk);
        chk("bp_in_ready1", 32'(in_ready), 32'd1);
        push(32'h204);
        @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_head0", pc_out, 32'h200);
        in_valid = 0; out_ready = 1;
        @(negedge clk);
        chk("bp_head1", pc_out, 32'h204);
        chk("bp_valid1", 32'(out_valid), 32'd1);
        chk("bp_in_ready_back", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // flush with two held plus one offered
        out_ready = 0; push(32'h300);
        @(negedge clk); push(32'h304);
        @(negedge clk); push(32'h308); flush = 1;
        @(negedge clk); in_valid = 0; flush = 0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_pc_kept", pc_out, 32'h300);
        out_ready = 1;
        @(negedge clk);
        chk("flush_no_third", 32'(out_valid), 32'd0);

        // flush discards an entry accepted in the same cycle
        out_ready = 0; push(32'h400);
        @(negedge clk); push(32'h404); flush = 1;
        @(negedge clk); in_valid = 0; flush = 0;
        chk("flush2_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("flush2_stays_empty", 32'(out_valid), 32'd0);
        out_ready = 1;

        // load extraction and RegWr gating table
        foreach (vt[i]) begin
            @(negedge clk);
            in_valid = 1; pc_in = 32'h500 + 32'(i);
            rd_data_in = vt[i].rd; addr_in = vt[i].addr; ld_size_in = vt[i].size;
            ld_signed_in = vt[i].sgn; wr_addr_in = vt[i].wr; RegWr_in = vt[i].rw;
            @(negedge clk);
            in_valid = 0;
            chk($sformatf("vec%0d_data", i), rd_data_out, vt[i].expData);
            chk($sformatf("vec%0d_misalign", i), 32'(misalign_out), 32'(vt[i].expMis));
            chk($sformatf("vec%0d_regwr", i), 32'(RegWr_out), 32'(vt[i].expRw));
            chk($sformatf("vec%0d_addr", i), 32'(addr_out), 32'(vt[i].addr));
        end

        // asynchronous reset while full
        @(negedge clk); out_ready = 0; push(32'h600);
        @(negedge clk); push(32'h604);
        @(negedge clk); in_valid = 0;
        #2 reset = 1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_pc", pc_out, 32'h8000_0000);
        chk("midrst_regwr", 32'(RegWr_out), 32'd0);
        @(negedge clk); reset = 0;

        // randomized traffic against a queue-based FIFO model
        pulseReset();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            chk("rnd_out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("rnd_in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() > 0) begin
                chk("rnd_pc", pc_out, q[0].pc);
                chk("rnd_rd_data", rd_data_out, refLoad(q[0].rd, q[0].addr, q[0].size, q[0].sgn));
                chk("rnd_alu", alu_out_out, q[0].alu);
                chk("rnd_ra", ra_out, q[0].ra);
                chk("rnd_wr_addr", 32'(wr_addr_out), 32'(q[0].wr));
                chk("rnd_addr", 32'(addr_out), 32'(q[0].addr));
                chk("rnd_memtoreg", 32'(MemtoReg_out), 32'(q[0].memtoReg));
                chk("rnd_misalign", 32'(misalign_out), 32'(refMis(q[0].addr, q[0].size)));
                chk("rnd_regwr", 32'(RegWr_out), 32'(q[0].regWr && q[0].wr != 5'd0));
            end else begin
                chk("rnd_regwr_empty", 32'(RegWr_out), 32'd0);
            end
            e.memtoReg = 2'($urandom); e.regWr = 1'($urandom); e.pc = $urandom;
            e.rd = $urandom; e.alu = $urandom; e.ra = $urandom;
            e.wr = 5'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            e.addr = 2'($urandom); e.size = 2'($urandom); e.sgn = 1'($urandom);
            drive(e);
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 19) == 0);
            acc  = in_valid && (q.size() < 2);
            cons = out_ready && (q.size() > 0);
            @(posedge clk);
            if (flush) begin
                q.delete();
            end else begin
                if (cons) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
        end

        @(negedge clk);
        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
